// File: rtl/div_sequencer.sv
// div_sequencer: sign/special-case wrapper around an unsigned divider.
// Handles RISC-V DIV/DIVU/REM/REMU semantics, divide-by-zero,
// signed overflow, divider timeout and flush.
// Ports:
//   CLK, rst             clock, async active-high reset
//   req_*                request handshake (op, rs1, rs2)
//   resp_*               response handshake (result, dz flag)
//   flush                abort any in-flight operation
//   div_start/dividend/divisor  launch to unsigned divider
//   div_done/quotient/remainder result from unsigned divider
// Optional: define DIV_RESULT_CACHE_EN to keep a one-entry cache
// of the last normal operation's signed-corrected q/r.
module div_sequencer #(
  parameter int XLEN        = 32,
  parameter int COUNT_WIDTH = 5
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_dz,
  input  logic            flush,
  output logic            div_start,
  output logic [XLEN-1:0] div_dividend,
  output logic [XLEN-1:0] div_divisor,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_quotient,
  input  logic [XLEN-1:0] div_remainder
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIX,
    RESP
  } state_t;

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  =
    {1'b1, {(XLEN-1){1'b0}}};

  state_t                 state;
  logic                   rem_q;
  logic                   s1_q;
  logic                   s2_q;
  logic [XLEN-1:0]        q_q;
  logic [XLEN-1:0]        r_q;
  logic [COUNT_WIDTH-1:0] cnt;

  // Request decode: op[0] selects unsigned, op[1] selects remainder
  logic            is_signed;
  logic            is_rem;
  logic            sa;
  logic            sb;
  logic            is_dz;
  logic            is_ovf;
  logic            accept;
  logic            hit;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] hit_res;

  assign is_signed = ~req_op[0];
  assign is_rem    = req_op[1];
  assign sa        = is_signed & req_rs1[XLEN-1];
  assign sb        = is_signed & req_rs2[XLEN-1];
  assign is_dz     = (req_rs2 == '0);
  assign is_ovf    = is_signed && (req_rs1 == MIN)
                     && (req_rs2 == ONES);
  assign accept    = req_valid & req_ready & ~flush;
  assign mag1      = sa ? -req_rs1 : req_rs1;
  assign mag2      = sb ? -req_rs2 : req_rs2;

  // Quotient sign follows the operand signs; remainder follows
  // the dividend.
  assign q_fix = (s1_q ^ s2_q) ? -q_q : q_q;
  assign r_fix = s1_q ? -r_q : r_q;

`ifdef DIV_RESULT_CACHE_EN
  logic            sgn_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic            c_valid;
  logic            c_sgn;
  logic [XLEN-1:0] c_rs1;
  logic [XLEN-1:0] c_rs2;
  logic [XLEN-1:0] c_q;
  logic [XLEN-1:0] c_r;

  assign hit = c_valid && (req_rs1 == c_rs1)
               && (req_rs2 == c_rs2)
               && (is_signed == c_sgn);
  assign hit_res = is_rem ? c_r : c_q;
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_result  <= '0;
      resp_dz      <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      rem_q        <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      q_q          <= '0;
      r_q          <= '0;
      cnt          <= '0;
`ifdef DIV_RESULT_CACHE_EN
      sgn_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      c_valid      <= 1'b0;
      c_sgn        <= 1'b0;
      c_rs1        <= '0;
      c_rs2        <= '0;
      c_q          <= '0;
      c_r          <= '0;
`endif
    end else if (flush) begin
      // Abort: a divider result still in flight lands in IDLE
      // and is ignored there.
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      div_start  <= 1'b0;
      cnt        <= '0;
`ifdef DIV_RESULT_CACHE_EN
      c_valid    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rem_q     <= is_rem;
            s1_q      <= sa;
            s2_q      <= sb;
            req_ready <= 1'b0;
            if (is_dz) begin
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_result <= is_rem ? req_rs1 : ONES;
              resp_dz     <= 1'b1;
            end else if (is_ovf) begin
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_result <= is_rem ? '0 : req_rs1;
              resp_dz     <= 1'b0;
            end else if (hit) begin
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_result <= hit_res;
              resp_dz     <= 1'b0;
            end else begin
              state        <= LAUNCH;
              div_start    <= 1'b1;
              div_dividend <= mag1;
              div_divisor  <= mag2;
`ifdef DIV_RESULT_CACHE_EN
              sgn_q        <= is_signed;
              a_q          <= req_rs1;
              b_q          <= req_rs2;
`endif
            end
          end
        end
        LAUNCH: begin
          div_start <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            q_q   <= div_quotient;
            r_q   <= div_remainder;
            state <= FIX;
          end else if (cnt == '1) begin
            // Divider never answered: give up with all-ones
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_result <= ONES;
            resp_dz     <= 1'b0;
            cnt         <= '0;
`ifdef DIV_RESULT_CACHE_EN
            c_valid     <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          state       <= RESP;
          resp_valid  <= 1'b1;
          resp_result <= rem_q ? r_fix : q_fix;
          resp_dz     <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
          c_valid     <= 1'b1;
          c_sgn       <= sgn_q;
          c_rs1       <= a_q;
          c_rs2       <= b_q;
          c_q         <= q_fix;
          c_r         <= r_fix;
`endif
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          div_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule
